// File: rtl/vga_frame_reader.sv
// Scans the 160x120 frame buffer in raster order and generates 640x480@60Hz VGA timing with 4x replication.
// Build option: define VGA_FULL_COLOUR_EN to output FB_DATA directly; otherwise FB_DATA[0] selects fg/bg colour.
module vga_frame_reader #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] CONFIG_COLOURS,
  output logic [14:0] FB_ADDR,
  input  logic [7:0]  FB_DATA,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [7:0]  VGA_COLOUR,
  output logic        FRAME_START
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       hcnt_q, hcnt_d;
  logic [9:0]       vcnt_q, vcnt_d;
  logic [14:0]      addr_q, addr_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic [7:0]       colour_q, colour_d;
  logic             frame_start_q, frame_start_d;
  logic             tick;
  logic             inVisible;
  logic [7:0]       pixel;
  logic             unused_bits;

  assign tick      = (div_q == DIV_LAST);
  assign inVisible = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);

`ifdef VGA_FULL_COLOUR_EN
  assign pixel       = FB_DATA;
  assign unused_bits = ^CONFIG_COLOURS;
`else
  assign pixel       = FB_DATA[0] ? CONFIG_COLOURS[15:8] : CONFIG_COLOURS[7:0];
  assign unused_bits = ^FB_DATA[7:1];
`endif

  // At a TICK the counters still hold the pixel just finished, so the output
  // stage samples them (and the FB_DATA fetched for them) before they advance.
  always_comb begin
    div_d         = tick ? '0 : div_q + 1'b1;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    colour_d      = colour_q;
    addr_d        = inVisible ? {vcnt_q[8:2], hcnt_q[9:2]} : 15'd0;
    frame_start_d = tick && (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
    if (tick) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
      hs_d     = !((hcnt_q >= HS_START) && (hcnt_q <= HS_END));
      vs_d     = !((vcnt_q >= VS_START) && (vcnt_q <= VS_END));
      colour_d = inVisible ? pixel : 8'h00;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_q         <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      addr_q        <= '0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      colour_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      addr_q        <= addr_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      colour_q      <= colour_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign FB_ADDR     = addr_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_COLOUR  = colour_q;
  assign FRAME_START = frame_start_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: a full-size 640x480 instance for line timing and a shrunken
// instance (CLK_DIV=3) so whole frames fit, both checked against an arithmetic raster model.
module tb_vga_frame_reader;

   localparam int FD  = 4;
   localparam int SD  = 3;
   localparam int SHV = 48, SHF = 4, SHS = 6, SHB = 6;
   localparam int SVV = 24, SVF = 2, SVS = 2, SVB = 3;
   localparam int SMALL_FRAME = (SHV + SHF + SHS + SHB) * (SVV + SVF + SVS + SVB) * SD;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [15:0] cfgColours;
   logic [14:0] addrFull, addrSmall;
   logic [7:0]  dataFull, dataSmall;
   logic        hsFull, vsFull, fsFull, hsSmall, vsSmall, fsSmall;
   logic [7:0]  colFull, colSmall;

   logic [7:0]  fbMem [0:32767];
   logic [15:0] cfgAtTickFull, cfgAtTickSmall;
   int          cyc;
   int          compared, mismatched;
   bit          checkEn;
   int          fallCount, lastFall, fsCount, lastFs;
   logic        hsPrev, fsPrev;

   vga_frame_reader dutFull (
      .CLK(CLK), .RESET(RESET), .CONFIG_COLOURS(cfgColours),
      .FB_ADDR(addrFull), .FB_DATA(dataFull),
      .VGA_HS(hsFull), .VGA_VS(vsFull), .VGA_COLOUR(colFull), .FRAME_START(fsFull)
   );

   vga_frame_reader #(
      .CLK_DIV(SD), .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
   ) dutSmall (
      .CLK(CLK), .RESET(RESET), .CONFIG_COLOURS(cfgColours),
      .FB_ADDR(addrSmall), .FB_DATA(dataSmall),
      .VGA_HS(hsSmall), .VGA_VS(vsSmall), .VGA_COLOUR(colSmall), .FRAME_START(fsSmall)
   );

   // 100MHz system clock
   always #5 CLK = ~CLK;

   // Synchronous-read dual-port buffer: data follows the address by one clock
   always @(posedge CLK) begin
      dataFull  <= fbMem[addrFull];
      dataSmall <= fbMem[addrSmall];
   end

   // Clocks since reset release, plus the colour configuration seen at each pixel tick
   always @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cyc <= 0;
      end else begin
         cyc <= cyc + 1;
         if ((cyc + 1) % FD == 0) cfgAtTickFull <= cfgColours;
         if ((cyc + 1) % SD == 0) cfgAtTickSmall <= cfgColours;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   function automatic logic [7:0] pixelColour(input logic [7:0] d, input logic [15:0] cfg);
`ifdef VGA_FULL_COLOUR_EN
      return d;
`else
      return d[0] ? cfg[15:8] : cfg[7:0];
`endif
   endfunction

   // Outputs after clock n come from the pixel the raster held before the most recent tick
   task automatic modelCheck(input string nm, input int n, input int d,
                             input int hv, input int hf, input int hsw, input int hb,
                             input int vv, input int vf, input int vsw, input int vb,
                             input logic [15:0] cfg, input logic [14:0] addr,
                             input logic hsO, input logic vsO, input logic [7:0] colO, input logic fsO);
      int ht, vt, tot, k, pos, h, v, p2, h2, v2;
      logic expHs, expVs, expFs;
      logic [7:0] expCol;
      logic [14:0] expAddr;
      ht = hv + hf + hsw + hb;
      vt = vv + vf + vsw + vb;
      tot = ht * vt;
      k = n / d;
      if (k == 0) begin
         expHs = 1'b1; expVs = 1'b1; expCol = 8'h00; expFs = 1'b0;
      end else begin
         pos = (k - 1) % tot;
         h = pos % ht;
         v = pos / ht;
         expHs = !((h >= hv + hf) && (h < hv + hf + hsw));
         expVs = !((v >= vv + vf) && (v < vv + vf + vsw));
         expCol = ((h < hv) && (v < vv)) ? pixelColour(fbMem[15'((v / 4) * 256 + h / 4)], cfg) : 8'h00;
         expFs = (n % d == 0) && (k % tot == 0);
      end
      if (n == 0) begin
         expAddr = 15'd0;
      end else begin
         p2 = ((n - 1) / d) % tot;
         h2 = p2 % ht;
         v2 = p2 / ht;
         expAddr = ((h2 < hv) && (v2 < vv)) ? 15'((v2 / 4) * 256 + h2 / 4) : 15'd0;
      end
      checkOutput({nm, ".hs"}, 32'(hsO), 32'(expHs));
      checkOutput({nm, ".vs"}, 32'(vsO), 32'(expVs));
      checkOutput({nm, ".colour"}, 32'(colO), 32'(expCol));
      checkOutput({nm, ".frameStart"}, 32'(fsO), 32'(expFs));
      checkOutput({nm, ".fbAddr"}, 32'(addr), 32'(expAddr));
   endtask

   // Sample away from the active edge; also measure HS and FRAME_START edge spacing
   always @(negedge CLK) begin
      if (checkEn) begin
         modelCheck("full", cyc, FD, 640, 16, 96, 48, 480, 10, 2, 33,
                    cfgAtTickFull, addrFull, hsFull, vsFull, colFull, fsFull);
         modelCheck("small", cyc, SD, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB,
                    cfgAtTickSmall, addrSmall, hsSmall, vsSmall, colSmall, fsSmall);
         if (RESET) begin
            fallCount = 0;
            fsCount = 0;
         end else begin
            if (hsPrev && !hsFull) begin
               if (fallCount == 0) checkOutput("hsFirstFall", 32'(cyc), 32'(656 * 4 + 4));
               else checkOutput("hsPeriod", 32'(cyc - lastFall), 32'd3200);
               fallCount++;
               lastFall = cyc;
            end
            if (!hsPrev && hsFull && fallCount > 0) checkOutput("hsLowWidth", 32'(cyc - lastFall), 32'd384);
            if (!fsPrev && fsSmall) begin
               if (fsCount == 0) checkOutput("fsFirst", 32'(cyc), 32'(SMALL_FRAME));
               else checkOutput("fsPeriod", 32'(cyc - lastFs), 32'(SMALL_FRAME));
               fsCount++;
               lastFs = cyc;
            end
         end
      end
      hsPrev = hsFull;
      fsPrev = fsSmall;
   end

   // Fill the buffer (while in reset), run the raster, then hit reset mid-stream
   task automatic applyStimulus(input int mode, input int runCycles, input bit randomCfg);
      int expFalls;
      for (int i = 0; i < 32768; i++) begin
         case (mode)
            0: fbMem[i] = 8'($urandom);
            1: fbMem[i] = 8'hFF;
            2: fbMem[i] = 8'h00;
            default: fbMem[i] = 8'hA5;
         endcase
      end
      if (mode == 2) begin
         fbMem[{7'd5, 8'd10}] = 8'h01;
         cfgColours = 16'hE01C;
      end
      @(negedge CLK);
      RESET = 1'b0;
      repeat (runCycles) begin
         @(negedge CLK);
         if (randomCfg && $urandom_range(0, 199) == 0) cfgColours = 16'($urandom);
      end
      @(posedge CLK);
      expFalls = (runCycles >= 2628) ? 1 + (runCycles - 2628) / 3200 : 0;
      checkOutput("hsFallCount", 32'(fallCount), 32'(expFalls));
      checkOutput("frameStartCount", 32'(fsCount), 32'(runCycles / SMALL_FRAME));
      #2 RESET = 1'b1;
      #1;
      checkOutput("rstImm.hs", 32'(hsFull), 32'd1);
      checkOutput("rstImm.vs", 32'(vsFull), 32'd1);
      checkOutput("rstImm.colour", 32'(colFull), 32'd0);
      checkOutput("rstImm.fs", 32'(fsFull), 32'd0);
      checkOutput("rstImm.smallColour", 32'(colSmall), 32'd0);
      checkOutput("rstImm.smallVs", 32'(vsSmall), 32'd1);
      repeat (3) @(posedge CLK);
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      checkEn = 1'b0;
      hsPrev = 1'b1;
      fsPrev = 1'b0;
      fallCount = 0;
      fsCount = 0;
      lastFall = 0;
      lastFs = 0;
      cfgColours = 16'hE01C;
      RESET = 1'b1;
      repeat (3) @(negedge CLK);
      checkEn = 1'b1;
      applyStimulus(0, 12000, 1'b1);
      applyStimulus(1, 7000, 1'b1);
      applyStimulus(2, 6500, 1'b0);
      applyStimulus(3, 3500, 1'b1);
      applyStimulus(0, 32'($urandom_range(2000, 4000)), 1'b1);
      applyStimulus(0, 6000, 1'b1);
      @(negedge CLK);
      checkEn = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
